// File: rtl/sha_compress.sv
// SHA-256 block compression: one round per cycle over a 16-word sliding message
// schedule, folding each block into the chaining state and emitting the final digest.
module sha_compress #(
  parameter int NW = 32,
  parameter int NB = 512,
  parameter int NR = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NB-1:0]   Block,
  input  logic            Start,
  input  logic            First,
  input  logic            Last,
  output logic            Ready,
  output logic [8*NW-1:0] Hash,
  output logic            Valid
);

  localparam int TW = $clog2(NR);

  localparam logic [8*NW-1:0] IV_VEC = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [NR*NW-1:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;

  function automatic logic [NW-1:0] rotr(input logic [NW-1:0] x, input int n);
    return (x >> n) | (x << (NW - n));
  endfunction

  function automatic logic [NW-1:0] big_s0(input logic [NW-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [NW-1:0] big_s1(input logic [NW-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [NW-1:0] small_s0(input logic [NW-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [NW-1:0] small_s1(input logic [NW-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [NW-1:0] ch(input logic [NW-1:0] x, input logic [NW-1:0] y,
                                       input logic [NW-1:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [NW-1:0] maj(input logic [NW-1:0] x, input logic [NW-1:0] y,
                                        input logic [NW-1:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [NW-1:0] iv(input int k);
    return IV_VEC[(7 - k)*NW +: NW];
  endfunction

  function automatic logic [NW-1:0] k_word(input logic [TW-1:0] idx);
    return K_TAB[(NR - 1 - int'(idx))*NW +: NW];
  endfunction

  state_t        state;
  logic [TW-1:0] t;
  logic          first_q;
  logic          last_q;
  logic [NW-1:0] hs [8];
  logic [NW-1:0] w  [16];
  logic [NW-1:0] wv [8];

  logic [NW-1:0]   t1;
  logic [NW-1:0]   t2;
  logic [NW-1:0]   w_new;
  logic [NW-1:0]   h_sum [8];
  logic [8*NW-1:0] h_flat;

  always_comb begin
    t1     = wv[7] + big_s1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_word(t) + w[0];
    t2     = big_s0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    w_new  = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
    h_flat = '0;
    for (int k = 0; k < 8; k++) begin
      // A First block starts from IV regardless of whatever H currently holds.
      h_sum[k] = (first_q ? iv(k) : hs[k]) + wv[k];
      h_flat[(7 - k)*NW +: NW] = h_sum[k];
    end
  end

  // Control and chaining state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      Ready   <= 1'b1;
      Valid   <= 1'b0;
      Hash    <= '0;
      t       <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      for (int k = 0; k < 8; k++) hs[k] <= iv(k);
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            first_q <= First;
            last_q  <= Last;
            t       <= '0;
            Ready   <= 1'b0;
            state   <= ROUND;
          end
        end
        ROUND: begin
          t <= t + 1'b1;
          if (t == TW'(NR - 1)) state <= UPDATE;
        end
        UPDATE: begin
          for (int k = 0; k < 8; k++) hs[k] <= h_sum[k];
          if (last_q) begin
            Hash  <= h_flat;
            Valid <= 1'b1;
          end
          Ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          Ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Message schedule window and working variables a..h (wv[0]..wv[7])
  always_ff @(posedge clk) begin
    if (state == IDLE && Start) begin
      for (int i = 0; i < 16; i++) w[i] <= Block[i*NW +: NW];
      for (int k = 0; k < 8; k++) wv[k] <= First ? iv(k) : hs[k];
    end else if (state == ROUND) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      wv[0] <= t1 + t2;
      wv[1] <= wv[0];
      wv[2] <= wv[1];
      wv[3] <= wv[2];
      wv[4] <= wv[3] + t1;
      wv[5] <= wv[4];
      wv[6] <= wv[5];
      wv[7] <= wv[6];
    end
  end

endmodule
